// File: rtl/instr_fetch_unit.sv
// Instruction-memory initiator: owns the PC, streams boot-load words into memory and
// prefetches instruction words into a small FIFO for decode. `FETCH_HALT_EN adds a halt word.
module instr_fetch_unit #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [15:0] START_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hF000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic        load_done,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_r_wr,
  output logic        mem_en_n,
  input  logic [15:0] mem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready,
  output logic        busy,
  output logic        halted
);

`ifdef FETCH_HALT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StFetch, StHalt} state_e;

  state_e          state_q, state_d;
  logic [15:0]     pc_q, pc_d;
  logic [15:0]     load_addr_q, load_addr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [15:0]     fifo_instr_q [DEPTH];
  logic [15:0]     fifo_pc_q    [DEPTH];

  logic fetch_en;
  logic flush;
  logic push;
  logic pop;
  logic not_empty;

  assign not_empty = (count_q != '0);

  // Control and memory-port drive; memory lines idle whenever no access is made.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    load_addr_d = load_addr_q;
    load_ready  = 1'b0;
    mem_en_n    = 1'b1;
    mem_r_wr    = 1'b1;
    mem_addr    = '0;
    mem_wdata   = '0;
    fetch_en    = 1'b0;
    flush       = 1'b0;
    case (state_q)
      StIdle: begin
        if (load_valid) begin
          state_d = StLoad;
        end else if (start) begin
          state_d = StFetch;
          pc_d    = START_PC;
        end
      end
      StLoad: begin
        load_ready = 1'b1;
        if (load_valid) begin
          mem_en_n    = 1'b0;
          mem_r_wr    = 1'b0;
          mem_addr    = load_addr_q;
          mem_wdata   = load_data;
          load_addr_d = load_addr_q + 16'd2;
        end
        if (load_done) begin
          state_d     = StIdle;
          load_addr_d = '0;
        end
      end
      StFetch, StHalt: begin
        if (redirect) begin
          flush   = 1'b1;
          pc_d    = redirect_pc & 16'hFFFE;
          state_d = StFetch;
        end else if ((state_q == StFetch) && (count_q < DepthCnt)) begin
          fetch_en = 1'b1;
          mem_en_n = 1'b0;
          mem_addr = pc_q;
          pc_d     = pc_q + 16'd2;
          if (HaltEn && (mem_rdata == HALT_WORD)) begin
            state_d = StHalt;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign push = fetch_en;
  assign pop  = not_empty && instr_ready && !flush;

  // FIFO pointers and occupancy; a flush empties the queue regardless of push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pc_q        <= START_PC;
      load_addr_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      load_addr_q <= load_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else if (push) begin
      fifo_instr_q[wr_ptr_q] <= mem_rdata;
      fifo_pc_q[wr_ptr_q]    <= pc_q;
    end
  end

  // Head is forced to zero when empty so stale entries never leak to decode.
  assign instr_valid = not_empty;
  assign instr       = not_empty ? fifo_instr_q[rd_ptr_q] : '0;
  assign instr_pc    = not_empty ? fifo_pc_q[rd_ptr_q] : '0;
  assign busy        = (state_q != StIdle);
  assign halted      = HaltEn && (state_q == StHalt);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit: a queue-level reference model is compared every
// cycle, plus literal checks of load, fetch latency, stall, redirect, halt and reset cases.
module tb_instr_fetch_unit;
  localparam int unsigned DEPTH     = 2;
  localparam logic [15:0] START_PC  = 16'h0000;
  localparam logic [15:0] HALT_WORD = 16'hF000;
`ifdef FETCH_HALT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_r_wr;
  logic        mem_en_n;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        busy;
  logic        halted;

  logic [15:0] dev_mem [32768];
  logic [15:0] ref_mem [32768];

  assign mem_rdata = dev_mem[mem_addr[15:1]];

  instr_fetch_unit #(
    .DEPTH    (DEPTH),
    .START_PC (START_PC),
    .HALT_WORD(HALT_WORD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_r_wr   (mem_r_wr),
    .mem_en_n   (mem_en_n),
    .mem_rdata  (mem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready),
    .busy       (busy),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {MIdle, MLoad, MFetch, MHalt} mstate_e;

  mstate_e     m_state;
  logic [15:0] m_pc;
  logic [15:0] m_la;
  logic [31:0] mq [$];

  int          n_cmp;
  int          n_err;
  logic        wr_pend;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        saw_read_38;
  logic [15:0] seen_halt_pc;
  logic [15:0] t1w [3];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = MIdle;
    m_pc    = START_PC;
    m_la    = 16'h0000;
    mq.delete();
  endtask

  // Expected outputs from the model state and the inputs currently applied.
  task automatic model_compare();
    logic        en_n_e, rw_e, lr_e, valid_e, busy_e, halted_e;
    logic [15:0] addr_e, wd_e;
    en_n_e = 1'b1; rw_e = 1'b1; lr_e = 1'b0; addr_e = '0; wd_e = '0;
    valid_e = 1'b0; busy_e = 1'b0; halted_e = 1'b0;
    if (reset) begin
      if (m_state == MLoad) begin
        lr_e = 1'b1;
        if (load_valid) begin
          en_n_e = 1'b0; rw_e = 1'b0; addr_e = m_la; wd_e = load_data;
        end
      end else if (m_state == MFetch && mq.size() < DEPTH && !redirect) begin
        en_n_e = 1'b0; addr_e = m_pc;
      end
      valid_e  = (mq.size() > 0);
      busy_e   = (m_state != MIdle);
      halted_e = (m_state == MHalt);
    end
    check("m load_ready", load_ready, lr_e);
    check("m mem_en_n", mem_en_n, en_n_e);
    check("m mem_r_wr", mem_r_wr, rw_e);
    check("m mem_addr", mem_addr, addr_e);
    check("m mem_wdata", mem_wdata, wd_e);
    check("m instr_valid", instr_valid, valid_e);
    check("m busy", busy, busy_e);
    check("m halted", halted, halted_e);
    if (valid_e) begin
      check("m instr", instr, mq[0][31:16]);
      check("m instr_pc", instr_pc, mq[0][15:0]);
    end
  endtask

  task automatic model_update();
    logic        do_push, do_pop;
    logic [15:0] w;
    if (!reset) begin
      model_reset();
      return;
    end
    case (m_state)
      MIdle: begin
        if (load_valid) m_state = MLoad;
        else if (start) begin
          m_state = MFetch;
          m_pc    = START_PC;
        end
      end
      MLoad: begin
        if (load_valid) begin
          ref_mem[m_la[15:1]] = load_data;
          m_la += 16'd2;
        end
        if (load_done) begin
          m_state = MIdle;
          m_la    = 16'h0000;
        end
      end
      default: begin
        if (redirect) begin
          mq.delete();
          m_pc    = redirect_pc & 16'hFFFE;
          m_state = MFetch;
        end else begin
          do_push = (m_state == MFetch) && (mq.size() < DEPTH);
          do_pop  = (mq.size() > 0) && instr_ready;
          if (do_pop) void'(mq.pop_front());
          if (do_push) begin
            w = ref_mem[m_pc[15:1]];
            mq.push_back({w, m_pc});
            if (HaltEn && w == HALT_WORD) m_state = MHalt;
            m_pc += 16'd2;
          end
        end
      end
    endcase
  endtask

  task automatic sample();
    @(negedge clk);
    model_compare();
    wr_pend = reset && !mem_en_n && !mem_r_wr;
    wr_addr = mem_addr;
    wr_data = mem_wdata;
    if (!mem_en_n && mem_r_wr && mem_addr == 16'h0038) saw_read_38 = 1'b1;
    if (instr_valid && instr == HALT_WORD) seen_halt_pc = instr_pc;
  endtask

  task automatic step();
    @(posedge clk);
    if (wr_pend) dev_mem[wr_addr[15:1]] = wr_data;
    model_update();
    #1;
  endtask

  task automatic cycle();
    sample();
    step();
  endtask

  task automatic check_reset_outputs();
    check("rst load_ready", load_ready, 1'b0);
    check("rst mem_en_n", mem_en_n, 1'b1);
    check("rst mem_r_wr", mem_r_wr, 1'b1);
    check("rst mem_addr", mem_addr, 16'h0000);
    check("rst mem_wdata", mem_wdata, 16'h0000);
    check("rst instr_valid", instr_valid, 1'b0);
    check("rst instr", instr, 16'h0000);
    check("rst instr_pc", instr_pc, 16'h0000);
    check("rst busy", busy, 1'b0);
    check("rst halted", halted, 1'b0);
  endtask

  // Called #1 after a rising edge; checks outputs react before the next edge.
  task automatic do_reset();
    reset = 1'b0; start = 1'b0; load_valid = 1'b0; load_done = 1'b0;
    redirect = 1'b0; instr_ready = 1'b0;
    #1;
    check_reset_outputs();
    cycle();
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] w;
    int          n, nbad;
    n_cmp = 0; n_err = 0;
    reset = 1'b0; start = 1'b0; load_valid = 1'b0; load_data = '0; load_done = 1'b0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    wr_pend = 1'b0; wr_addr = '0; wr_data = '0; saw_read_38 = 1'b0; seen_halt_pc = 16'hFFFF;
    t1w[0] = 16'h0120; t1w[1] = 16'h0121; t1w[2] = 16'h23FF;
    for (int i = 0; i < 32768; i++) begin
      w = 16'($urandom);
      if (w == HALT_WORD) w = w ^ 16'h0001;
      dev_mem[i] = w;
      ref_mem[i] = w;
    end
    model_reset();
    #2;
    check_reset_outputs();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Boot load of three words.
    load_valid = 1'b1; load_data = t1w[0];
    cycle();
    for (int i = 0; i < 3; i++) begin
      load_data = t1w[i];
      load_done = (i == 2);
      sample();
      check("t1 load_ready", load_ready, 1'b1);
      check("t1 mem_en_n", mem_en_n, 1'b0);
      check("t1 mem_r_wr", mem_r_wr, 1'b0);
      check("t1 mem_addr", mem_addr, 16'(2 * i));
      check("t1 mem_wdata", mem_wdata, t1w[i]);
      step();
    end
    load_valid = 1'b0; load_done = 1'b0;
    sample();
    check("t1 busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) check("t1 stored", dev_mem[i], t1w[i]);
    step();

    // Start fetching with decode always ready.
    start = 1'b1;
    cycle();
    start = 1'b0; instr_ready = 1'b1;
    sample();
    check("t2 valid early", instr_valid, 1'b0);
    check("t2 first read addr", mem_addr, 16'h0000);
    step();
    for (int i = 0; i < 3; i++) begin
      sample();
      check("t2 valid", instr_valid, 1'b1);
      check("t2 instr", instr, t1w[i]);
      check("t2 instr_pc", instr_pc, 16'(2 * i));
      step();
    end

    // Decode stalled: FIFO fills, fetch stops, then the stream resumes intact.
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (DEPTH + 2) cycle();
    sample();
    check("t3 stalled en_n", mem_en_n, 1'b1);
    check("t3 head pc", instr_pc, 16'h0000);
    step();
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample();
      check("t3 resume pc", instr_pc, 16'(2 * i));
      step();
    end

    // Redirect with a full FIFO.
    instr_ready = 1'b0;
    repeat (DEPTH + 2) cycle();
    redirect = 1'b1; redirect_pc = 16'h0011;
    sample();
    check("t4 no access", mem_en_n, 1'b1);
    step();
    redirect = 1'b0;
    sample();
    check("t4 flushed", instr_valid, 1'b0);
    check("t4 new pc", mem_addr, 16'h0010);
    check("t4 reading", mem_en_n, 1'b0);
    step();
    sample();
    check("t4 first pc", instr_pc, 16'h0010);
    step();

`ifdef FETCH_HALT_EN
    dev_mem[16'h0036 >> 1] = HALT_WORD;
    ref_mem[16'h0036 >> 1] = HALT_WORD;
    redirect = 1'b1; redirect_pc = 16'h0030; instr_ready = 1'b1;
    cycle();
    redirect = 1'b0; saw_read_38 = 1'b0; seen_halt_pc = 16'hFFFF;
    repeat (10) cycle();
    sample();
    check("t5 halted", halted, 1'b1);
    check("t5 halt pc", seen_halt_pc, 16'h0036);
    check("t5 no read 0x38", 16'(saw_read_38), 16'h0000);
    step();
    redirect = 1'b1; redirect_pc = 16'h0000;
    cycle();
    redirect = 1'b0;
    sample();
    check("t5 resumed", halted, 1'b0);
    check("t5 restart addr", mem_addr, 16'h0000);
    check("t5 restart en_n", mem_en_n, 1'b0);
    step();
`endif

    // Reset in the middle of fetch, then in the middle of a load write.
    instr_ready = 1'b1;
    repeat (3) cycle();
    do_reset();
    load_valid = 1'b1; load_data = 16'hBEEF;
    cycle();
    check("t6 write active", mem_en_n, 1'b0);
    do_reset();

    // Randomised episodes.
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      n = $urandom_range(4, 40);
      for (int c = 0; c < n; c++) begin
        load_valid  = (c == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
        load_data   = 16'($urandom);
        load_done   = (c == n - 1);
        start       = (c == 0);
        redirect    = ($urandom_range(0, 9) == 0);
        redirect_pc = 16'($urandom);
        instr_ready = 1'($urandom);
        cycle();
      end
      load_valid = 1'b0; load_done = 1'b0; start = 1'b1; redirect = 1'b0;
      cycle();
      for (int c = 0; c < 250; c++) begin
        if (ep == 2 && c == 120) do_reset();
        instr_ready = ($urandom_range(0, 9) < 6);
        redirect    = ($urandom_range(0, 11) == 0);
        redirect_pc = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 100));
        start       = 1'($urandom);
        load_valid  = ($urandom_range(0, 15) == 0);
        load_done   = 1'($urandom);
        load_data   = 16'($urandom);
        cycle();
      end
    end

    nbad = 0;
    for (int i = 0; i < 32768; i++) if (dev_mem[i] !== ref_mem[i]) nbad++;
    check("final memory image", 16'(nbad), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
